// File: rtl/seg_scan_decoder_if.sv
// Multiplexed seven-segment bus plus decoded-result signals for seg_scan_decoder.
// The display side drives the pins (master); the decoder samples them (slave).
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic                    err_pulse;
  logic                    frame_done;

  modport master (
    output seg_n, dp_n, an_n,
    input  digits_out, digit_valid, dp_out, err_pulse, frame_done
  );

  modport slave (
    input  seg_n, dp_n, an_n,
    output digits_out, digit_valid, dp_out, err_pulse, frame_done
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Samples an active-low multiplexed seven-segment bus and recovers the hex value per digit.
// Optional macro SEG_SCAN_DP_CAPTURE_EN adds decimal-point capture and compare.
//
// state  | meaning
// IDLE   | no digit addressed, waiting for a one-hot anode sample
// SETTLE | counting consecutive identical samples against the reference
// HOLD   | digit captured, waiting for the bus to change
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic clk,
  input  logic rst,
  seg_scan_decoder_if.slave bus
);

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int SW = NUM_DIGITS + 7 + DPW;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sync1, sync2, ref_q, ref_d, raw;
  logic             cap_q, cap_d;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q, dp_q, mask_q, mask_or;
  logic                    err_q, frame_q;

  logic [NUM_DIGITS-1:0] samp_an, ref_an;
  logic [6:0]            ref_seg;
  logic                  addressed;
  logic [4:0]            dec;
  logic                  legal, blank;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  assign raw = {bus.an_n, bus.seg_n, bus.dp_n};
`else
  assign raw = {bus.an_n, bus.seg_n};
`endif

  assign samp_an   = sync2[SW-1 -: NUM_DIGITS];
  assign ref_an    = ref_q[SW-1 -: NUM_DIGITS];
  assign ref_seg   = ref_q[DPW +: 7];
  assign addressed = ($countones(~samp_an) == 1);

  // seg is gfedcba, active-low; returns {legal, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = 5'h10;
      7'b1111001: seg_decode = 5'h11;
      7'b0100100: seg_decode = 5'h12;
      7'b0110000: seg_decode = 5'h13;
      7'b0011001: seg_decode = 5'h14;
      7'b0010010: seg_decode = 5'h15;
      7'b0000010: seg_decode = 5'h16;
      7'b1111000: seg_decode = 5'h17;
      7'b0000000: seg_decode = 5'h18;
      7'b0010000: seg_decode = 5'h19;
      7'b0001000: seg_decode = 5'h1A;
      7'b0000011: seg_decode = 5'h1B;
      7'b1000110: seg_decode = 5'h1C;
      7'b0100001: seg_decode = 5'h1D;
      7'b0000110: seg_decode = 5'h1E;
      7'b0001110: seg_decode = 5'h1F;
      default:    seg_decode = 5'h00;
    endcase
  endfunction

  assign dec     = seg_decode(ref_seg);
  assign legal   = dec[4];
  assign blank   = &ref_seg;
  assign mask_or = mask_q | ~ref_an;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ref_q   <= '1;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    cap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (addressed) begin
          cnt_d   = CNT_W'(1);
          ref_d   = sync2;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 == ref_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            cap_d   = 1'b1;
            state_d = HOLD;
          end
        end else if (!addressed) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = CNT_W'(1);
          ref_d = sync2;
        end
      end
      HOLD: begin
        if (sync2 != ref_q) begin
          if (addressed) begin
            cnt_d   = CNT_W'(1);
            ref_d   = sync2;
            state_d = SETTLE;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // ref_q is still the captured sample on the cycle after entering HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      frame_q <= 1'b0;
      if (cap_q) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!ref_an[i]) begin
            valid_q[i] <= legal;
            if (legal) digits_q[4*i +: 4] <= dec[3:0];
`ifdef SEG_SCAN_DP_CAPTURE_EN
            dp_q[i] <= ~ref_q[0];
`endif
          end
        end
        err_q <= !legal && !blank;
        if (&mask_or) begin
          mask_q  <= '0;
          frame_q <= 1'b1;
        end else begin
          mask_q <= mask_or;
        end
      end
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.err_pulse   = err_q;
  assign bus.frame_done  = frame_q;
`ifdef SEG_SCAN_DP_CAPTURE_EN
  assign bus.dp_out = dp_q;
`else
  assign bus.dp_out = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: hand sequences for reset/latency corners,
// then a vector table whose expected states go through a scoreboard queue.
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          cyc;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dpm;
    int          errs;
    int          frames;
  } vec_t;

  vec_t vecs[14];
  vec_t sbq[$];
  vec_t e;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int frame_seen = 0;
  bit saw4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.err_pulse === 1'b1) err_seen++;
      if (bus.frame_done === 1'b1) frame_seen++;
      if (bus.digit_valid[1] === 1'b1 && bus.digits_out[7:4] === 4'h4) saw4 = 1;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    bus.an_n  = an;
    bus.seg_n = seg;
    bus.dp_n  = dp;
  endtask

  function automatic logic [3:0] dp_exp(input logic [3:0] m);
`ifdef SEG_SCAN_DP_CAPTURE_EN
    return m;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [31:0] all_out();
    return {bus.digits_out, bus.digit_valid, bus.dp_out, bus.err_pulse, bus.frame_done, 6'b0};
  endfunction

  initial begin
    //          an       seg          dp  cyc  digits    valid    dpm      err frm
    vecs[0]  = '{4'b1101, 7'b0011001, 1, 10, 16'h0003, 4'b0001, 4'b0000, 0, 0};
    vecs[1]  = '{4'b1101, 7'b0010010, 1, 30, 16'h0053, 4'b0011, 4'b0000, 0, 0};
    vecs[2]  = '{4'b1110, 7'b1010101, 1, 20, 16'h0053, 4'b0010, 4'b0000, 1, 0};
    vecs[3]  = '{4'b1110, 7'b1111111, 1, 25, 16'h0053, 4'b0010, 4'b0000, 0, 0};
    vecs[4]  = '{4'b1100, 7'b0110000, 1, 40, 16'h0053, 4'b0010, 4'b0000, 0, 0};
    vecs[5]  = '{4'b1110, 7'b1111001, 1, 20, 16'h0051, 4'b0011, 4'b0000, 0, 0};
    vecs[6]  = '{4'b1101, 7'b0100100, 1, 20, 16'h0021, 4'b0011, 4'b0000, 0, 0};
    vecs[7]  = '{4'b1011, 7'b0110000, 0, 20, 16'h0321, 4'b0111, 4'b0100, 0, 0};
    vecs[8]  = '{4'b0111, 7'b0011001, 1, 20, 16'h4321, 4'b1111, 4'b0100, 0, 1};
    vecs[9]  = '{4'b1110, 7'b1111001, 1, 20, 16'h4321, 4'b1111, 4'b0100, 0, 0};
    vecs[10] = '{4'b1101, 7'b0100100, 1, 20, 16'h4321, 4'b1111, 4'b0100, 0, 0};
    vecs[11] = '{4'b1011, 7'b0110000, 0, 20, 16'h4321, 4'b1111, 4'b0100, 0, 0};
    vecs[12] = '{4'b0111, 7'b0011001, 1, 20, 16'h4321, 4'b1111, 4'b0100, 0, 1};
    vecs[13] = '{4'b1111, 7'b1111111, 1, 30, 16'h4321, 4'b1111, 4'b0100, 0, 0};

    // reset with random pins
    rst = 1'b1;
    drive(4'($urandom), 7'($urandom), 1'($urandom));
    tick(1);
    drive(4'($urandom), 7'($urandom), 1'($urandom));
    tick(1);
    chk("reset_outputs", all_out(), 32'h0);
    drive(4'b1111, 7'b1111111, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk($sformatf("idle_cycle%0d", i), all_out(), 32'h0);
    end

    // latency: visible on edge 19, not on edge 18
    err_seen = 0;
    frame_seen = 0;
    drive(4'b1110, 7'b0110000, 1'b1);
    tick(18);
    chk("latency_edge18_valid", {28'h0, bus.digit_valid}, 32'h0);
    tick(1);
    chk("latency_edge19_valid", {28'h0, bus.digit_valid}, 32'h1);
    chk("latency_edge19_digit", {16'h0, bus.digits_out}, 32'h0003);
    tick(11);
    chk("steady_no_err", err_seen, 0);
    chk("steady_no_frame", frame_seen, 0);

    // table vectors through the scoreboard
    saw4 = 0;
    for (int i = 0; i < 14; i++) begin
      sbq.push_back(vecs[i]);
      drive(vecs[i].an, vecs[i].seg, vecs[i].dp);
      err_seen = 0;
      frame_seen = 0;
      tick(vecs[i].cyc);
      e = sbq.pop_front();
      chk($sformatf("vec%0d_digits", i), {16'h0, bus.digits_out}, {16'h0, e.digits});
      chk($sformatf("vec%0d_valid", i), {28'h0, bus.digit_valid}, {28'h0, e.valid});
      chk($sformatf("vec%0d_dp", i), {28'h0, bus.dp_out}, {28'h0, dp_exp(e.dpm)});
      chk($sformatf("vec%0d_err_count", i), err_seen, e.errs);
      chk($sformatf("vec%0d_frame_count", i), frame_seen, e.frames);
    end
    chk("glitch_value4_never_written", {31'h0, saw4}, 32'h0);

    // reset in the middle of settling leaves no stale capture
    drive(4'b0111, 7'b0000000, 1'b1);
    tick(10);
    rst = 1'b1;
    drive(4'b1111, 7'b1111111, 1'b1);
    tick(1);
    rst = 1'b0;
    chk("mid_settle_reset_outputs", all_out(), 32'h0);
    err_seen = 0;
    frame_seen = 0;
    tick(30);
    chk("mid_settle_no_stale_capture", all_out(), 32'h0);
    chk("mid_settle_no_pulses", err_seen + frame_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-segment encoder: it samples a multiplexed, active-low seven-segment bus (segments plus digit anodes) and recovers the hex value shown on each digit.
- It filters for stability and flags illegal patterns.
- It is used to loop back and check display-driver output, and to read an external display into the design.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits / anode lines
STABLE_CYCLES, 16, consecutive identical samples required before capture (min 2)
CNT_W, 5, stability counter width; must hold STABLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
seg_n  input  7  segment lines, active-low, bit0=a .. bit6=g
dp_n  input  1  decimal point line, active-low
an_n  input  NUM_DIGITS  digit anodes, active-low, one-hot when a digit is driven
digits_out  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  1 = digit i holds a legal decoded value
dp_out  output  NUM_DIGITS  captured decimal points (see Optional Feature)
err_pulse  output  1  one-cycle pulse on capture of an illegal, non-blank pattern
frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse

Behaviour:
- Reset: clock is clk; reset is synchronous, active-high on rst. On rst=1 at a clock edge, all of the following clear:
  - digits_out=0, digit_valid=0, dp_out=0, err_pulse=0, frame_done=0.
  - Sync registers are loaded with all-ones (bus idle).
  - Counter=0, captured mask=0, FSM=IDLE.
- Input path: seg_n, dp_n and an_n pass through a 2-flop synchroniser. All logic below uses stage-2 values.
- One-hot check: a sample is "addressed" when exactly one bit of the synchronised an_n is 0. Zero or multiple low bits count as not addressed.
- FSM:
  - IDLE: when addressed, load the counter with 1, latch {an, seg, dp} as reference, go to SETTLE.
  - SETTLE: if the sample equals the reference and is addressed, increment the counter.
    - When the counter reaches STABLE_CYCLES, perform the capture and go to HOLD.
    - Otherwise, if the sample is not addressed, go to IDLE with counter=0.
    - Otherwise (addressed but different from the reference), reload the reference and set counter=1.
  - HOLD: stay while the sample equals the reference. Any change goes to IDLE, or straight to SETTLE with counter=1 if the new sample is addressed. This guarantees one capture per display window.
- Capture, registered and visible the cycle after entering HOLD:
  - Decode table, seg_n as gfedcba:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - Legal pattern: write the nibble to the addressed digit and set digit_valid[i].
  - Blank pattern 1111111: digit_valid[i]=0, nibble unchanged, no error.
  - Any other pattern: digit_valid[i]=0, nibble unchanged, err_pulse=1 for one cycle.
  - In all three cases, set captured mask bit i.
- Latency: a clean, constant pin value appears on the outputs STABLE_CYCLES+3 clk edges after it settles (2 sync + STABLE_CYCLES count + 1 output register).
- frame_done: pulses one cycle when the captured mask becomes all-ones. The mask clears in the same cycle.
  - When frame_done and a new capture coincide, the new capture's bit is set in the cleared mask.
  - NUM_DIGITS=1 gives a pulse on every capture.
- rst mid-SETTLE discards the partial count. Digit registers clear; no stale capture follows.

Optional Feature:
- Macro: SEG_SCAN_DP_CAPTURE_EN.
- Defined: at each capture, dp_out[i] is set to the inverted dp_n of the reference sample. dp_n is part of the stability compare.
- Undefined: dp_out is tied to 0, and dp_n is excluded from both the synchroniser and the compare, so toggling the point never restarts settling.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0. After release with bus idle, outputs stay 0 for 50 cycles.
- Steady digit: an_n=1110, seg_n=0110000 held 30 cycles -> digits_out[3:0]=3 and digit_valid=0001, exactly 19 edges after the inputs are applied. No err_pulse.
- Glitch rejection: an_n=1101 with seg_n=0011001 for 10 cycles, then switch to 0010010 held 30 cycles -> digit 1 = 5 only. Value 4 is never written.
- Illegal/blank: digit 0 holds 1010101 for 20 cycles -> err_pulse exactly once, digit_valid[0]=0. Then 1111111 -> no err_pulse.
- Multi-anode: an_n=1100 with a legal pattern for 40 cycles -> no capture, no state change.
- Full scan: digits 0..3 driven in turn with 1,2,3,4, 20 cycles each, repeated twice -> digits_out=16'h4321, digit_valid=1111, frame_done pulses once per scan pass. With the macro defined and dp_n=0 on digit 2 -> dp_out=0100.
